// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-addressed little-endian data RAM with valid/ready
// request and response handshakes, a fixed access latency and fault
// reporting for misaligned, out-of-range and illegal-control accesses.
module data_memory_hs #(
   parameter int    DEPTH     = 1024,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_ctrl,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   // DMCtrl encodings (funct3)
   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
   } req_t;

   logic [31:0]   mem [DEPTH];

   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   req_t          held, cur;
   logic          accept, commit, fault;
   logic [AW-1:0] idx;
   logic [3:0]    lane_we;
   logic [31:0]   lane_data, word, load_data;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;

   // Request in flight: live inputs while idle (LATENCY=1 commits on the
   // accepting edge), the latched copy once accepted.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cur = held;
      if (state == IDLE) cur = '{we: req_we, addr: req_addr, wdata: req_wdata, ctrl: req_ctrl};
   end

   // Next state, counter and handshake outputs.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               cnt_nx = CNT_LOAD;
               if (LATENCY > 1) begin
                  state_nx = WAIT;
               end else begin
                  state_nx = RESP;
                  commit   = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nx = RESP;
               commit   = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Fault detection on the request in flight.
   always_comb begin
      fault = 1'b0;
      case (cur.ctrl)
         CTRL_B, CTRL_H, CTRL_W: ;
         CTRL_BU, CTRL_HU:       if (cur.we) fault = 1'b1;
         default:                fault = 1'b1;
      endcase
      if ((cur.ctrl == CTRL_H || cur.ctrl == CTRL_HU) && cur.addr[0]) fault = 1'b1;
      if (cur.ctrl == CTRL_W && cur.addr[1:0] != 2'b00)               fault = 1'b1;
      if (cur.addr[31:AW+2] != '0)                                     fault = 1'b1;
   end

   // Store lane enables and replicated write data.
   always_comb begin
      idx       = cur.addr[AW+1:2];
      lane_we   = 4'b0000;
      lane_data = cur.wdata;
      case (cur.ctrl)
         CTRL_B: begin
            lane_we   = 4'b0001 << cur.addr[1:0];
            lane_data = {4{cur.wdata[7:0]}};
         end
         CTRL_H: begin
            lane_we   = cur.addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{cur.wdata[15:0]}};
         end
         CTRL_W:  lane_we = 4'b1111;
         default: lane_we = 4'b0000;
      endcase
   end

   // Load lane selection and extension.
   always_comb begin
      word      = mem[idx];
      byte_sel  = word[{cur.addr[1:0], 3'b000} +: 8];
      half_sel  = cur.addr[1] ? word[31:16] : word[15:0];
      load_data = '0;
      case (cur.ctrl)
         CTRL_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
         CTRL_BU: load_data = {24'h0, byte_sel};
         CTRL_H:  load_data = {{16{half_sel[15]}}, half_sel};
         CTRL_HU: load_data = {16'h0, half_sel};
         CTRL_W:  load_data = word;
         default: load_data = '0;
      endcase
   end

   // RAM write port: commits on the edge that enters RESP.
   // NOTE: the RAM array has no reset branch; its contents must survive rst.
   always_ff @(posedge clk) begin
      if (commit && !fault && cur.we && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   // FSM state and latency counter.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Request latch and response data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held      <= '0;
         rsp_rdata <= '0;
         rsp_fault <= 1'b0;
      end else begin
         if (accept) held <= cur;
         if (commit) begin
            rsp_fault <= fault;
            rsp_rdata <= (fault || cur.we) ? 32'h0 : load_data;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: one LATENCY=2 instance for function
// tests plus LATENCY 1/4/15 instances for timing and throughput.
module tb_data_memory_hs;

   localparam logic [2:0] B   = 3'b000;
   localparam logic [2:0] H   = 3'b001;
   localparam logic [2:0] W   = 3'b010;
   localparam logic [2:0] BAD = 3'b011;
   localparam logic [2:0] BU  = 3'b100;
   localparam logic [2:0] HU  = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_ctrl;
   logic        rsp_ready;
   logic [3:0]  req_ready, rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata [4];

   int n_vec = 0;
   int n_err = 0;
   int cycle = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 15;
      data_memory_hs #(.DEPTH(1024), .LATENCY(LAT), .INIT_FILE("")) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_we    (req_we),
         .req_addr  (req_addr),
         .req_wdata (req_wdata),
         .req_ctrl  (req_ctrl),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_fault (rsp_fault[g])
      );
   end

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         2:       return 4;
         default: return 15;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction on instance k with rsp_ready held high.
   task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl,
                         output logic [31:0] rdata, output logic fault,
                         output int lat, output int acc);
      int n;
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready[k]), 32'd1);
      req_we = we; req_addr = addr; req_wdata = wdata; req_ctrl = ctrl;
      req_valid[k] = 1'b1;
      @(posedge clk); #1;
      acc = cycle;
      req_valid[k] = 1'b0;
      n = 0;
      while (!rsp_valid[k] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      lat   = n + 1;
      rdata = rsp_rdata[k];
      fault = rsp_fault[k];
      if (rsp_valid[k]) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic xact(input string tag, input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl,
                       input logic [31:0] exp_data, input logic exp_fault);
      logic [31:0] d;
      logic        f;
      int          lat, acc;
      do_req(k, we, addr, wdata, ctrl, d, f, lat, acc);
      check({tag, "_lat"},   32'(lat), 32'(lat_of(k)));
      check({tag, "_data"},  d, exp_data);
      check({tag, "_fault"}, 32'(f), 32'(exp_fault));
   endtask

   initial begin
      logic [31:0] d;
      logic        f;
      int          lat, a0, a1, n;

      rst = 1'b1; req_valid = '0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_ctrl = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready[0]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[0], 32'h0);
      check("rst_rsp_fault", 32'(rsp_fault[0]), 32'd0);
      @(negedge clk) rst = 1'b0;

      // Basic byte store / load
      xact("st_b0", 0, 1'b1, 32'h0, 32'h0000_0057, B, 32'h0, 1'b0);
      xact("ld_b0", 0, 1'b0, 32'h0, 32'h0, B, 32'h0000_0057, 1'b0);

      // Word store then narrow loads with extension
      xact("st_w8",  0, 1'b1, 32'h8, 32'hDEAD_BEEF, W, 32'h0, 1'b0);
      xact("ld_hA",  0, 1'b0, 32'hA, 32'h0, H,  32'hFFFF_DEAD, 1'b0);
      xact("ld_huA", 0, 1'b0, 32'hA, 32'h0, HU, 32'h0000_DEAD, 1'b0);
      xact("ld_b9",  0, 1'b0, 32'h9, 32'h0, B,  32'hFFFF_FFBE, 1'b0);
      xact("ld_bu8", 0, 1'b0, 32'h8, 32'h0, BU, 32'h0000_00EF, 1'b0);

      // Narrow stores only touch their lanes
      xact("st_bB",  0, 1'b1, 32'hB, 32'hFFFF_FF11, B, 32'h0, 1'b0);
      xact("st_h8",  0, 1'b1, 32'h8, 32'hFFFF_2B7F, H, 32'h0, 1'b0);
      xact("ld_w8",  0, 1'b0, 32'h8, 32'h0, W, 32'h11AD_2B7F, 1'b0);

      // Faulting accesses leave memory untouched
      xact("st_w0",    0, 1'b1, 32'h0,    32'hA5A5_A5A5, W,   32'h0, 1'b0);
      xact("st_h1",    0, 1'b1, 32'h1,    32'h0000_2B7F, H,   32'h0, 1'b1);
      xact("st_bad",   0, 1'b1, 32'h0,    32'h0000_2B7F, BAD, 32'h0, 1'b1);
      xact("st_oor",   0, 1'b1, 32'h1000, 32'h0000_2B7F, W,   32'h0, 1'b1);
      xact("st_bu",    0, 1'b1, 32'h0,    32'h0000_0011, BU,  32'h0, 1'b1);
      xact("ld_w0",    0, 1'b0, 32'h0,    32'h0, W, 32'hA5A5_A5A5, 1'b0);
      xact("ld_oor",   0, 1'b0, 32'h1000, 32'h0, W, 32'h0, 1'b1);
      xact("ld_w2",    0, 1'b0, 32'h2,    32'h0, W, 32'h0, 1'b1);

      // Response back-pressure: held response, held next request
      rsp_ready = 1'b0;
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h8; req_ctrl = W; req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_addr = 32'h0; req_ctrl = B;
      n = 0;
      while (!rsp_valid[0] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold_valid_up", 32'(rsp_valid[0]), 32'd1);
      repeat (5) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid[0]), 32'd1);
         check("hold_data",  rsp_rdata[0], 32'h11AD_2B7F);
         check("hold_ready", 32'(req_ready[0]), 32'd0);
      end
      @(negedge clk) rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("hs_valid_low", 32'(rsp_valid[0]), 32'd0);
      check("hs_idle",      32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      check("next_accepted", 32'(req_ready[0]), 32'd0);
      req_valid[0] = 1'b0;
      n = 0;
      while (!rsp_valid[0] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("next_data", rsp_rdata[0], 32'hFFFF_FFA5);
      @(posedge clk); #1;

      // Reset during WAIT aborts a pending store
      xact("st_w10",  0, 1'b1, 32'h10, 32'h0BAD_F00D, W, 32'h0, 1'b0);
      xact("ld_w10a", 0, 1'b0, 32'h10, 32'h0, W, 32'h0BAD_F00D, 1'b0);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678; req_ctrl = W;
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("wait_busy", 32'(req_ready[0]), 32'd0);
      rst = 1'b1;
      #1;
      check("arst_req_ready", 32'(req_ready[0]), 32'd1);
      check("arst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("arst_rsp_rdata", rsp_rdata[0], 32'h0);
      check("arst_rsp_fault", 32'(rsp_fault[0]), 32'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      xact("ld_w10b", 0, 1'b0, 32'h10, 32'h0, W, 32'h0BAD_F00D, 1'b0);

      // Latency sweep and back-to-back throughput on every instance
      for (int k = 0; k < 4; k++) begin
         do_req(k, 1'b1, 32'h20, 32'hC0DE_0000 | 32'(k), W, d, f, lat, a0);
         check("sweep_st_lat", 32'(lat), 32'(lat_of(k)));
         do_req(k, 1'b0, 32'h20, 32'h0, W, d, f, lat, a1);
         check("sweep_ld_lat",  32'(lat), 32'(lat_of(k)));
         check("sweep_ld_data", d, 32'hC0DE_0000 | 32'(k));
         check("sweep_spacing", 32'(a1 - a0), 32'(lat_of(k) + 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
